// File: rtl/alu_cmd_issuer.sv
// Command issuer for a combinational 32-bit ALU: accepts tagged commands, waits a settle window, returns tagged results.
// Optional: define ALU_FLAGS_EN to add rsp_zero/rsp_neg flag outputs.
module alu_cmd_issuer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int TAG_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [3:0]       alu_opcode,
  output logic [31:0]      alu_operand1,
  output logic [31:0]      alu_operand2,
  input  logic [31:0]      alu_result,
  input  logic             alu_carry_out,
  input  logic [63:0]      alu_product,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [63:0]      rsp_data,
  output logic             rsp_carry,
  output logic             busy,
  output logic [15:0]      cmd_count
`ifdef ALU_FLAGS_EN
  ,
  output logic             rsp_zero,
  output logic             rsp_neg
`endif
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_INCR = 4'd3;
  localparam logic [3:0] OP_DECR = 4'd4;

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("alu_cmd_issuer: SETTLE_CYCLES must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t     state;
  logic [3:0] settle_cnt;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Carry and upper product bits are stale for unrelated opcodes, so mask them here.
  logic        is_mul, is_arith;
  logic [63:0] cap_data;
  logic        cap_carry;

  always_comb begin
    is_mul   = (alu_opcode == OP_MUL);
    is_arith = (alu_opcode == OP_ADD) || (alu_opcode == OP_SUB) ||
               (alu_opcode == OP_INCR) || (alu_opcode == OP_DECR);
    cap_data  = is_mul ? alu_product : {32'b0, alu_result};
    cap_carry = is_arith ? alu_carry_out : 1'b0;
  end

`ifdef ALU_FLAGS_EN
  logic cap_zero, cap_neg;
  always_comb begin
    cap_zero = is_mul ? (cap_data == 64'b0) : (cap_data[31:0] == 32'b0);
    cap_neg  = is_mul ? cap_data[63] : cap_data[31];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      alu_opcode   <= '0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      rsp_valid    <= 1'b0;
      rsp_tag      <= '0;
      rsp_data     <= '0;
      rsp_carry    <= 1'b0;
      cmd_count    <= '0;
`ifdef ALU_FLAGS_EN
      rsp_zero     <= 1'b0;
      rsp_neg      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_opcode   <= cmd_opcode;
            alu_operand1 <= cmd_a;
            alu_operand2 <= cmd_b;
            rsp_tag      <= cmd_tag;
            settle_cnt   <= 4'(SETTLE_CYCLES - 1);
            state        <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == 4'd0) begin
            rsp_data  <= cap_data;
            rsp_carry <= cap_carry;
`ifdef ALU_FLAGS_EN
            rsp_zero  <= cap_zero;
            rsp_neg   <= cap_neg;
`endif
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_count <= cmd_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator side of the 32-bit ALU opcode/operand interface: ADD, SUB, MUL, INCR, DECR, logic ops and shifts.
- Accepts tagged commands on a valid/ready stream and drives opcode plus operands into the ALU.
- Waits a fixed settle window, then captures result, carry and 64-bit product.
- Returns one tagged response per command on a second valid/ready stream. Sits between a sequencer/testbench master and the combinational ALU.

Parameters:
- SETTLE_CYCLES, 2: cycles between driving the ALU and capturing its outputs. Legal range 1..15; 0 is illegal.
- TAG_W, 4: width of the command/response tag.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  issuer can accept a command
- cmd_opcode  in  4  ALU opcode: 0 ADD, 1 SUB, 2 MUL, 3 INCR, 4 DECR, 5-11 logic, 12-15 shifts
- cmd_a  in  32  operand1
- cmd_b  in  32  operand2
- cmd_tag  in  TAG_W  opaque tag, echoed on the response
- alu_opcode  out  4  registered opcode to the ALU
- alu_operand1  out  32  registered operand1 to the ALU
- alu_operand2  out  32  registered operand2 to the ALU
- alu_result  in  32  ALU result
- alu_carry_out  in  1  ALU carry/borrow
- alu_product  in  64  ALU product
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_tag  out  TAG_W  echoed tag
- rsp_data  out  64  captured result
- rsp_carry  out  1  captured carry
- busy  out  1  high whenever state != IDLE
- cmd_count  out  16  completed-response counter

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - alu_opcode, alu_operand1, alu_operand2, rsp_valid, rsp_tag, rsp_data, rsp_carry, busy and cmd_count all 0.
  - cmd_valid is ignored while rst=1.
- FSM states: IDLE, SETTLE, RESP.
- cmd_ready = (state==IDLE), combinational from state. busy = !IDLE.
- IDLE:
  - On cmd_valid&&cmd_ready at an edge: register opcode, operands and tag onto alu_*/tag registers.
  - Load settle counter with SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE:
  - Counter decrements each edge.
  - On the edge where the counter is 0, capture outputs, set rsp_valid=1 and go to RESP.
  - If the opcode is MUL: rsp_data=alu_product, rsp_carry=0.
  - If the opcode is ADD/SUB/INCR/DECR: rsp_data={32'b0,alu_result}, rsp_carry=alu_carry_out.
  - For every other opcode: rsp_data={32'b0,alu_result}, rsp_carry=0. The ALU's carry/product hold stale values for non-matching opcodes and must not leak through.
- RESP:
  - rsp_valid, rsp_tag, rsp_data and rsp_carry hold stable until rsp_valid&&rsp_ready.
  - On that handshake edge: rsp_valid=0, cmd_count++ (wraps 0xFFFF->0), return to IDLE.
- Latency and throughput:
  - Command accepted at edge t gives rsp_valid high after edge t+SETTLE_CYCLES.
  - With rsp_ready held high, the response completes at edge t+SETTLE_CYCLES+1 and the next accept is possible at t+SETTLE_CYCLES+2.
  - Throughput is 1 command per SETTLE_CYCLES+2 cycles. No overlap, and only one command is outstanding.
- alu_opcode/alu_operand* hold their last values in IDLE and RESP; they change only on accept.
- Backpressure: rsp_ready low keeps the FSM in RESP; cmd_ready stays 0 and no new command is accepted.
- Reset mid-operation (SETTLE or RESP): in-flight command dropped, no response emitted, cmd_count cleared.
- No cmd_valid/rsp_valid combinational path exists: rsp_* are registered, and cmd_ready depends on state only.

Optional Feature:
- ALU_FLAGS_EN defined:
  - Adds output ports rsp_zero (1) and rsp_neg (1), registered at capture and held with rsp_data. Both reset to 0.
  - MUL: zero = (rsp_data==0), neg = rsp_data[63].
  - Other opcodes: zero = (rsp_data[31:0]==0), neg = rsp_data[31].
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- ADD a=0xFFFFFFFF b=0x1 tag=3, SETTLE_CYCLES=2, rsp_ready=1 -> rsp_valid rises 2 edges after accept; rsp_data=0, rsp_carry=1, rsp_tag=3; cmd_count=1.
- MUL a=0x00010000 b=0x00010000 -> rsp_data=0x0000000100000000, rsp_carry=0.
- SUB a=5 b=7, then XOR a=0xF0F0F0F0 b=0xFFFFFFFF, rsp_ready=1:
  - SUB response: rsp_data=0xFFFFFFFE, carry=1.
  - XOR response: rsp_data=0x0F0F0F0F, carry=0 even though the ALU carry is stale-high.
  - Accepts spaced exactly 4 cycles; cmd_count=2.
- Backpressure: rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp_* stable, cmd_ready=0, busy=1, second command accepted only on the edge after the response handshake.
- Assert rst during SETTLE of ADD 1+1 -> all outputs 0 immediately (async), no rsp_valid after release, cmd_count=0, next command behaves normally.
- With ALU_FLAGS_EN, DECR a=0 -> rsp_data=0xFFFFFFFF, rsp_neg=1, rsp_zero=0, rsp_carry=1. AND a=0xAAAA0000 b=0x5555FFFF -> rsp_zero=1, rsp_neg=0.
